// File: rtl/iq_stats_pkg.sv
// Shared types, constants and helpers for the I/Q block-statistics estimator.
// Contents: FSM state enum, drain length, accumulator width helpers and the
// saturating negate used to turn a mean into an offset-correction word.
package iq_stats_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Cycles needed to flush the input and product registers after the last sample
  localparam int unsigned DRAIN_CYCLES = 2;

  // Sum accumulator width: one sample width plus log2 of the sample count
  function automatic int unsigned sum_width(input int unsigned in_w, input int unsigned log2_n);
    return in_w + log2_n;
  endfunction

  // Second-moment accumulator width: product width plus log2 of the sample count
  function automatic int unsigned moment_width(input int unsigned in_w, input int unsigned log2_n);
    return 2 * in_w + log2_n;
  endfunction

  // -mean, with the most negative value mapped to the most positive one.
  // Works on a 32-bit container; the caller narrows the result to in_w bits.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] mean,
                                                 input int unsigned       in_w);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (in_w - 1));
    if (mean == most_neg) sat_neg = ~most_neg;
    else                  sat_neg = -mean;
  endfunction

endpackage

// File: rtl/iq_stats_estimator_if.sv
// Sample/control/result bundle of the I/Q statistics estimator.
// master: sample source and result consumer (drives samples, start).
// slave : the estimator (drives busy, done, result_valid and result words).
interface iq_stats_estimator_if #(
  parameter int unsigned INPUT_WIDTH = 14
);

  logic signed [INPUT_WIDTH-1:0]   IQ_i_real;
  logic signed [INPUT_WIDTH-1:0]   IQ_i_imag;
  logic                            sample_en;
  logic                            start;
  logic                            busy;
  logic                            done;
  logic                            result_valid;
  logic signed [INPUT_WIDTH-1:0]   Bvect1;
  logic signed [INPUT_WIDTH-1:0]   Bvect2;
  logic signed [2*INPUT_WIDTH-1:0] m2_real;
  logic signed [2*INPUT_WIDTH-1:0] m2_imag;
  logic signed [2*INPUT_WIDTH-1:0] m2_cross;

  modport master (
    output IQ_i_real, IQ_i_imag, sample_en, start,
    input  busy, done, result_valid, Bvect1, Bvect2, m2_real, m2_imag, m2_cross
  );

  modport slave (
    input  IQ_i_real, IQ_i_imag, sample_en, start,
    output busy, done, result_valid, Bvect1, Bvect2, m2_real, m2_imag, m2_cross
  );

endinterface

// File: rtl/iq_stats_accum.sv
// Signed accumulator with synchronous clear and enable.
// Ports: clk, rst (sync, active-high), clr (clear, wins over en), en (add din),
// din (signed IN_WIDTH), acc (signed WIDTH running sum, sign-extended adds).
module iq_stats_accum #(
  parameter int unsigned IN_WIDTH = 14,
  parameter int unsigned WIDTH    = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [IN_WIDTH-1:0] din,
  output logic signed [WIDTH-1:0]    acc
);

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= acc + WIDTH'(din);
  end

endmodule

// File: rtl/iq_stats_estimator.sv
// Block-average estimator for raw I/Q samples: on start, accumulates 2^LOG2_N
// qualified samples, then publishes -round(mean) offset words (Bvect1/Bvect2)
// and, when IQ_STATS_SECOND_MOMENT_EN is defined, E[r^2], E[i^2], E[r*i].
// Ports: clk, rst (sync, active-high), bus (slave side of iq_stats_estimator_if;
// its INPUT_WIDTH must match this module's INPUT_WIDTH).
// Macro IQ_STATS_SECOND_MOMENT_EN: builds the multipliers and moment
// accumulators; without it m2_* are tied to 0 and timing is unchanged.
module iq_stats_estimator
  import iq_stats_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 14,
  parameter int unsigned LOG2_N      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  iq_stats_estimator_if.slave  bus
);

  localparam int unsigned W  = INPUT_WIDTH;
  localparam int unsigned PW = 2 * INPUT_WIDTH;
  localparam int unsigned SW = sum_width(INPUT_WIDTH, LOG2_N);
  localparam int unsigned DW = $clog2(DRAIN_CYCLES);
  localparam logic signed [SW-1:0] HALF = SW'(1 << (LOG2_N - 1));

  state_e state_q, state_d;
  logic [LOG2_N-1:0] cnt_q;
  logic [DW-1:0]     dcnt_q;
  logic accept_start, accept_sample, last_sample, drain_last;

  // Pipeline: input register (stage 1) and product/delay register (stage 2)
  logic                v1_q, v2_q;
  logic signed [W-1:0] in_r_q, in_i_q, d_r_q, d_i_q;

  logic signed [SW-1:0] sum_r, sum_i;
  logic signed [W-1:0]  mean_r, mean_i, bvect1_c, bvect2_c;

  logic                busy_q, done_q, valid_q;
  logic signed [W-1:0] bvect1_q, bvect2_q;

  // Qualifier decode
  always_comb begin
    accept_start  = (state_q == S_IDLE) && bus.start;
    accept_sample = (state_q == S_ACCUM) && bus.sample_en;
    last_sample   = accept_sample && (cnt_q == '1);
    drain_last    = (state_q == S_DRAIN) && (dcnt_q == DW'(DRAIN_CYCLES - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_start) state_d = S_ACCUM;
      S_ACCUM: if (last_sample)  state_d = S_DRAIN;
      S_DRAIN: if (drain_last)   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sample and drain counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dcnt_q <= '0;
    end else begin
      if (accept_start)       cnt_q <= '0;
      else if (accept_sample) cnt_q <= cnt_q + LOG2_N'(1);
      if (state_q == S_DRAIN) dcnt_q <= dcnt_q + DW'(1);
      else                    dcnt_q <= '0;
    end
  end

  // Data pipeline; the valid bits carry the ACCUM qualification with the data
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      in_r_q <= '0;
      in_i_q <= '0;
      d_r_q  <= '0;
      d_i_q  <= '0;
    end else begin
      v1_q   <= accept_sample;
      in_r_q <= bus.IQ_i_real;
      in_i_q <= bus.IQ_i_imag;
      v2_q   <= v1_q;
      d_r_q  <= in_r_q;
      d_i_q  <= in_i_q;
    end
  end

  iq_stats_accum #(.IN_WIDTH(W), .WIDTH(SW)) u_sum_r (
    .clk(clk), .rst(rst), .clr(accept_start), .en(v2_q), .din(d_r_q), .acc(sum_r)
  );

  iq_stats_accum #(.IN_WIDTH(W), .WIDTH(SW)) u_sum_i (
    .clk(clk), .rst(rst), .clr(accept_start), .en(v2_q), .din(d_i_q), .acc(sum_i)
  );

  // Mean rounds half toward +inf; the result always fits in W bits
  always_comb begin
    mean_r   = W'((sum_r + HALF) >>> LOG2_N);
    mean_i   = W'((sum_i + HALF) >>> LOG2_N);
    bvect1_c = W'(sat_neg(32'(mean_r), W));
    bvect2_c = W'(sat_neg(32'(mean_i), W));
  end

  // Status and offset outputs; busy drops together with the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      bvect1_q <= '0;
      bvect2_q <= '0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        valid_q  <= 1'b1;
        bvect1_q <= bvect1_c;
        bvect2_q <= bvect2_c;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = valid_q;
  assign bus.Bvect1       = bvect1_q;
  assign bus.Bvect2       = bvect2_q;

`ifdef IQ_STATS_SECOND_MOMENT_EN
  localparam int unsigned MW = moment_width(INPUT_WIDTH, LOG2_N);

  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q;
  logic signed [MW-1:0] mom_rr, mom_ii, mom_ri;
  logic signed [PW-1:0] m2_real_q, m2_imag_q, m2_cross_q;

  // Product register, aligned with the sum delay register
  always_ff @(posedge clk) begin
    if (rst) begin
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ri_q <= '0;
    end else begin
      p_rr_q <= PW'(in_r_q) * PW'(in_r_q);
      p_ii_q <= PW'(in_i_q) * PW'(in_i_q);
      p_ri_q <= PW'(in_r_q) * PW'(in_i_q);
    end
  end

  iq_stats_accum #(.IN_WIDTH(PW), .WIDTH(MW)) u_mom_rr (
    .clk(clk), .rst(rst), .clr(accept_start), .en(v2_q), .din(p_rr_q), .acc(mom_rr)
  );

  iq_stats_accum #(.IN_WIDTH(PW), .WIDTH(MW)) u_mom_ii (
    .clk(clk), .rst(rst), .clr(accept_start), .en(v2_q), .din(p_ii_q), .acc(mom_ii)
  );

  iq_stats_accum #(.IN_WIDTH(PW), .WIDTH(MW)) u_mom_ri (
    .clk(clk), .rst(rst), .clr(accept_start), .en(v2_q), .din(p_ri_q), .acc(mom_ri)
  );

  // Moments are floor-divided by the sample count
  always_ff @(posedge clk) begin
    if (rst) begin
      m2_real_q  <= '0;
      m2_imag_q  <= '0;
      m2_cross_q <= '0;
    end else if (state_q == S_DONE) begin
      m2_real_q  <= PW'(mom_rr >>> LOG2_N);
      m2_imag_q  <= PW'(mom_ii >>> LOG2_N);
      m2_cross_q <= PW'(mom_ri >>> LOG2_N);
    end
  end

  assign bus.m2_real  = m2_real_q;
  assign bus.m2_imag  = m2_imag_q;
  assign bus.m2_cross = m2_cross_q;
`else
  assign bus.m2_real  = '0;
  assign bus.m2_imag  = '0;
  assign bus.m2_cross = '0;
`endif

endmodule
